param_sdp_ram: RTL and testbench

Parametrised simple-dual-port synchronous RAM, the next generation of the team's single-port 64x8 RAM. It has one write port with byte enables and one independent read port with a registered output and a valid flag. Read-during-write behaviour is selectable. A built-in clear engine initialises every word after reset or on request. It serves as the generic on-chip buffer for datapath and FIFO blocks.

---
 rtl/param_sdp_ram_if.sv | 29 ++
 rtl/param_sdp_ram.sv | 105 ++++++++++
 tb/tb_param_sdp_ram.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/param_sdp_ram_if.sv
// Bus bundle for param_sdp_ram: write port, read port and clear-engine handshake.
interface param_sdp_ram_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned BYTE_W = 8
);
  localparam int unsigned NB = DATA_W / BYTE_W;

  logic              clr_req;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [NB-1:0]     wbe;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] q;
  logic              q_valid;

  modport master (
    output clr_req, we, waddr, wdata, wbe, re, raddr,
    input  busy, q, q_valid
  );

  modport slave (
    input  clr_req, we, waddr, wdata, wbe, re, raddr,
    output busy, q, q_valid
  );
endinterface

// File: rtl/param_sdp_ram.sv
// Simple-dual-port RAM with byte enables, registered read, selectable read-during-write
// and a clear engine that sweeps CLEAR_VAL through every word after reset or on request.
module param_sdp_ram #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       BYTE_W    = 8,
  parameter int unsigned       RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic            clock,
  input logic            reset,
  param_sdp_ram_if.slave bus
);
  localparam int unsigned NB    = DATA_W / BYTE_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic               clr_we;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               waddr_ok, raddr_ok, wr_en, rd_en;
  logic [IDX_W-1:0]   waddr_idx, raddr_idx;
  logic [DATA_W-1:0]  rd_word;

  assign waddr_ok  = 32'(bus.waddr) < DEPTH;
  assign raddr_ok  = 32'(bus.raddr) < DEPTH;
  assign waddr_idx = bus.waddr[IDX_W-1:0];
  assign raddr_idx = bus.raddr[IDX_W-1:0];
  assign wr_en     = (state_q == StIdle) && bus.we && waddr_ok;
  assign rd_en     = (state_q == StIdle) && bus.re;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      StClear: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + IDX_W'(1);
        if (32'(clr_ptr_q) == DEPTH - 1) begin
          state_d   = StIdle;
          clr_ptr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Out-of-range reads return zero; write-through merges only the enabled lanes.
  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      rd_word = mem[raddr_idx];
      if (RDW_MODE == 1 && wr_en && bus.raddr == bus.waddr) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wbe[i]) rd_word[i*BYTE_W +: BYTE_W] = bus.wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
    q_d       = rd_en ? rd_word : q_q;
    q_valid_d = rd_en;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Storage array carries no reset; the clear engine initialises it.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_ptr_q] <= CLEAR_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) mem[waddr_idx][i*BYTE_W +: BYTE_W] <= bus.wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign bus.busy    = (state_q == StClear);
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
endmodule

// File: tb/tb_param_sdp_ram.sv
// Directed bench: three RAM instances (read-first, write-through, 48-deep) share one stimulus.
module tb_param_sdp_ram;
  logic        clock, reset;
  logic        clr_req, we, re;
  logic [5:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;

  int n_checks = 0;
  int n_errors = 0;

  param_sdp_ram_if #(.DATA_W(32), .ADDR_W(6), .BYTE_W(8)) if0 ();
  param_sdp_ram_if #(.DATA_W(32), .ADDR_W(6), .BYTE_W(8)) if1 ();
  param_sdp_ram_if #(.DATA_W(32), .ADDR_W(6), .BYTE_W(8)) if2 ();

  param_sdp_ram #(.DATA_W(32), .ADDR_W(6), .DEPTH(16), .BYTE_W(8), .RDW_MODE(0),
                  .CLEAR_VAL(32'hA5A5A5A5))
    dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
  param_sdp_ram #(.DATA_W(32), .ADDR_W(6), .DEPTH(16), .BYTE_W(8), .RDW_MODE(1),
                  .CLEAR_VAL(32'hA5A5A5A5))
    dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
  param_sdp_ram #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .BYTE_W(8), .RDW_MODE(0),
                  .CLEAR_VAL(32'h0))
    dut2 (.clock(clock), .reset(reset), .bus(if2.slave));

  assign if0.clr_req = clr_req;
  assign if0.we      = we;
  assign if0.waddr   = waddr;
  assign if0.wdata   = wdata;
  assign if0.wbe     = wbe;
  assign if0.re      = re;
  assign if0.raddr   = raddr;
  assign if1.clr_req = clr_req;
  assign if1.we      = we;
  assign if1.waddr   = waddr;
  assign if1.wdata   = wdata;
  assign if1.wbe     = wbe;
  assign if1.re      = re;
  assign if1.raddr   = raddr;
  assign if2.clr_req = clr_req;
  assign if2.we      = we;
  assign if2.waddr   = waddr;
  assign if2.wdata   = wdata;
  assign if2.wbe     = wbe;
  assign if2.re      = re;
  assign if2.raddr   = raddr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be; re = 1'b0;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    we = 1'b0; re = 1'b1; raddr = a;
    step();
    re = 1'b0;
  endtask

  // Counts busy cycles per instance; user ports stay active until the first instance idles.
  task automatic measure_busy(input bit pulse, output int c0, output int c1, output int c2,
                              output bit qv_bad);
    bit pb0, pb2;
    c0 = 0; c1 = 0; c2 = 0; qv_bad = 1'b0; pb0 = 1'b1; pb2 = 1'b1;
    for (int i = 0; i < 200 && (if0.busy || if1.busy || if2.busy); i++) begin
      if (if0.busy) c0++;
      if (if1.busy) c1++;
      if (if2.busy) c2++;
      if ((pb0 && if0.q_valid) || (pb2 && if2.q_valid)) qv_bad = 1'b1;
      clr_req = pulse && (i == 5);
      if (!if0.busy || !if2.busy) begin
        we = 1'b0;
        re = 1'b0;
      end
      pb0 = if0.busy;
      pb2 = if2.busy;
      step();
    end
    clr_req = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  initial begin
    int  c0, c1, c2;
    bit  qv_bad;
    reset = 1'b1; clr_req = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    step();
    step();
    check("rst_q", if0.q, 32'h0);
    check("rst_qv", {31'b0, if0.q_valid}, 32'h0);
    check("rst_busy", {31'b0, if0.busy}, 32'h1);

    reset = 1'b0;
    measure_busy(1'b0, c0, c1, c2, qv_bad);
    check("init_busy16_a", c0, 32'd16);
    check("init_busy16_b", c1, 32'd16);
    check("init_busy48", c2, 32'd48);

    for (int a = 0; a < 16; a++) begin
      rd(6'(a));
      check("init_rd", if0.q, 32'hA5A5A5A5);
      check("init_rd_qv", {31'b0, if0.q_valid}, 32'h1);
    end
    step();
    check("qv_drop", {31'b0, if0.q_valid}, 32'h0);
    check("q_hold", if0.q, 32'hA5A5A5A5);

    wr(6'd3, 32'h11223344, 4'b0101);
    rd(6'd3);
    check("be_merge0", if0.q, 32'hA522A544);
    check("be_merge1", if1.q, 32'hA522A544);
    check("be_merge2", if2.q, 32'h00220044);

    wr(6'd5, 32'h0, 4'hF);
    we = 1'b1; waddr = 6'd5; wdata = 32'hFF; wbe = 4'hF; re = 1'b1; raddr = 6'd5;
    step();
    we = 1'b0; re = 1'b0;
    check("rdw_old", if0.q, 32'h0);
    check("rdw_new", if1.q, 32'hFF);
    check("rdw_old2", if2.q, 32'h0);
    rd(6'd5);
    check("rdw_after", if0.q, 32'hFF);
    we = 1'b1; waddr = 6'd6; wdata = 32'hAB; wbe = 4'hF; re = 1'b1; raddr = 6'd5;
    step();
    we = 1'b0; re = 1'b0;
    check("indep_wt", if1.q, 32'hFF);

    for (int a = 0; a < 16; a++) wr(6'(a), 32'hFF, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    we = 1'b1; waddr = 6'd0; wdata = 32'h12345678; wbe = 4'hF; re = 1'b1; raddr = 6'd0;
    measure_busy(1'b1, c0, c1, c2, qv_bad);
    check("clr_busy16", c0, 32'd16);
    check("clr_busy48", c2, 32'd48);
    check("clr_qv_blocked", {31'b0, qv_bad}, 32'h0);
    for (int a = 0; a < 16; a++) begin
      rd(6'(a));
      check("clr_rd", if0.q, 32'hA5A5A5A5);
    end
    rd(6'd0);
    check("clr_rd48", if2.q, 32'h0);

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    #1;
    check("mid_rst_q", if0.q, 32'h0);
    check("mid_rst_qv", {31'b0, if0.q_valid}, 32'h0);
    step();
    check("mid_rst_busy", {31'b0, if0.busy}, 32'h1);
    reset = 1'b0;
    measure_busy(1'b0, c0, c1, c2, qv_bad);
    check("rerun_busy16", c0, 32'd16);
    check("rerun_busy48", c2, 32'd48);

    wr(6'd47, 32'hCAFEF00D, 4'hF);
    wr(6'd50, 32'h77, 4'hF);
    rd(6'd50);
    check("oor_q", if2.q, 32'h0);
    check("oor_qv", {31'b0, if2.q_valid}, 32'h1);
    rd(6'd47);
    check("in_range47", if2.q, 32'hCAFEF00D);
    check("oor47_d16", if0.q, 32'h0);
    rd(6'd2);
    check("no_alias", if0.q, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
